uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_arb_pkg.sv | 26 ++
 rtl/rr_priority_picker.sv | 29 ++
 rtl/uart_tx_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART TX arbiter: FSM encoding, parameter
// defaults and a one-hot to index helper.
package uart_arb_pkg;

  localparam int unsigned DEF_NUM_REQ      = 4;
  localparam int unsigned DEF_LOCK_MAX     = 16;
  localparam int unsigned DEF_IDLE_TIMEOUT = 255;
  localparam int unsigned MAX_NUM_REQ      = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_GAP  = 2'd2
  } arb_state_e;

  // Index of the set bit of a one-hot vector (0 when the vector is zero).
  function automatic logic [2:0] onehot_to_idx(input logic [MAX_NUM_REQ-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < MAX_NUM_REQ; i++) begin
      if (oh[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: the search starts one position after
// i_ptr and wraps; the first requesting index wins (one-hot, or zero).
module rr_priority_picker #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IW-1:0]      i_ptr,
  output logic [NUM_REQ-1:0] o_gnt
);

  logic          found;
  logic [IW-1:0] idx;

  // Scan requesters in rotated order ptr+1, ptr+2, ... ptr and grant the first.
  always_comb begin
    o_gnt = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = IW'((32'(i_ptr) + i) % NUM_REQ);
      if (!found && i_req[idx]) begin
        o_gnt[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Arbitrates several byte-stream requesters onto a single UART TX FIFO write
// port. One owner holds the port for a whole frame; every accepted byte is
// followed by a one-cycle GAP carrying the write strobe. Ownership is
// released at end of frame, after LOCK_MAX bytes, or after IDLE_TIMEOUT
// cycles with the owner's valid low.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ      = DEF_NUM_REQ,
  parameter int unsigned LOCK_MAX     = DEF_LOCK_MAX,
  parameter int unsigned IDLE_TIMEOUT = DEF_IDLE_TIMEOUT
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [NUM_REQ-1:0]   i_req_valid,
  input  logic [8*NUM_REQ-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]   i_req_last,
  output logic [NUM_REQ-1:0]   o_req_ready,
  output logic                 o_write,
  output logic [7:0]           o_write_data,
  input  logic                 i_write_data_full,
  output logic [NUM_REQ-1:0]   o_grant,
  output logic                 o_busy
);

  localparam int unsigned IW  = $clog2(NUM_REQ);
  localparam int unsigned BCW = $clog2(LOCK_MAX + 1);
  localparam int unsigned ICW = $clog2(IDLE_TIMEOUT + 1);

  arb_state_e         state_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [IW-1:0]      ptr_q;
  logic [BCW-1:0]     byte_cnt_q, byte_cnt_d;
  logic [ICW-1:0]     idle_cnt_q, idle_cnt_d;
  logic               release_q;
  logic               write_q;
  logic [7:0]         wdata_q;

  logic [NUM_REQ-1:0] pick;
  logic [IW-1:0]      owner_idx;
  logic               in_own;
  logic               own_valid;
  logic               own_last;
  logic [7:0]         own_data;
  logic               accept;
  logic               lock_hit;
  logic               idle_expire;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .i_req (i_req_valid),
    .i_ptr (ptr_q),
    .o_gnt (pick)
  );

  assign owner_idx = IW'(onehot_to_idx(MAX_NUM_REQ'(grant_q)));

  // Owner-side view of the request bus, handshake and saturating counter steps.
  always_comb begin
    in_own    = (state_q == ST_OWN);
    own_valid = |(i_req_valid & grant_q);
    own_last  = |(i_req_last & grant_q);
    own_data  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (grant_q[k]) own_data = own_data | i_req_data[8*k +: 8];
    end
    accept      = in_own && own_valid && !i_write_data_full;
    o_req_ready = in_own ? (grant_q & {NUM_REQ{~i_write_data_full}}) : '0;
    byte_cnt_d  = (byte_cnt_q >= BCW'(LOCK_MAX)) ? byte_cnt_q : byte_cnt_q + BCW'(1);
    lock_hit    = (byte_cnt_d >= BCW'(LOCK_MAX));
    idle_cnt_d  = (idle_cnt_q >= ICW'(IDLE_TIMEOUT)) ? idle_cnt_q : idle_cnt_q + ICW'(1);
    idle_expire = (idle_cnt_d >= ICW'(IDLE_TIMEOUT));
  end

  // Arbitration FSM with registered grant, write strobe and write data.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      ptr_q      <= IW'(NUM_REQ - 1);
      byte_cnt_q <= '0;
      idle_cnt_q <= '0;
      release_q  <= 1'b0;
      write_q    <= 1'b0;
      wdata_q    <= '0;
    end else begin
      write_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (|i_req_valid) begin
            grant_q    <= pick;
            byte_cnt_q <= '0;
            idle_cnt_q <= '0;
            state_q    <= ST_OWN;
          end
        end
        ST_OWN: begin
          if (accept) begin
            write_q    <= 1'b1;
            wdata_q    <= own_data;
            byte_cnt_q <= byte_cnt_d;
            idle_cnt_q <= '0;
            release_q  <= own_last || lock_hit;
            state_q    <= ST_GAP;
          end else if (!own_valid && !i_write_data_full) begin
            if (idle_expire) begin
              grant_q    <= '0;
              ptr_q      <= owner_idx;
              idle_cnt_q <= '0;
              state_q    <= ST_IDLE;
            end else begin
              idle_cnt_q <= idle_cnt_d;
            end
          end
        end
        ST_GAP: begin
          if (release_q) begin
            grant_q   <= '0;
            ptr_q     <= owner_idx;
            release_q <= 1'b0;
            state_q   <= ST_IDLE;
          end else begin
            state_q <= ST_OWN;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_write      = write_q;
  assign o_write_data = wdata_q;
  assign o_grant      = grant_q;
  assign o_busy       = (state_q != ST_IDLE);

endmodule
